// File: rtl/fire_request_controller.sv
// Turns debounced press pulses into req/ack fire requests with ammo tracking,
// a bounded shot queue and a post-shot cooldown. Optional: FIRE_CTRL_AUTO_RELOAD_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; leaves as soon as a shot is queued
// REQ   | fire_req held high until fire_ack is sampled
// COOL  | forced gap after an acknowledged shot (down-counter to zero)

module fire_request_controller #(
    parameter int AMMO_MAX      = 8,
    parameter int PEND_MAX      = 3,
    parameter int COOLDOWN      = 4,
    parameter int RELOAD_CYCLES = 16
) (
    input  logic                          fclk,
    input  logic                          reset_n,
    input  logic                          press_pulse,
    input  logic                          reload,
    input  logic                          fire_ack,
    output logic                          fire_req,
    output logic [$clog2(AMMO_MAX+1)-1:0] ammo,
    output logic [$clog2(PEND_MAX+1)-1:0] pending,
    output logic                          empty,
    output logic                          drop_pulse
);

    localparam int AW = $clog2(AMMO_MAX + 1);
    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int MW = (AW > PW) ? AW : PW;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_MAX);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);
    localparam logic [CW-1:0] COOL_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cool_cnt;
    logic [CW-1:0] cool_cnt_next;

    logic          accept;
    logic          ack_take;
    logic          auto_fire;
    logic          refill;
    logic [AW-1:0] ammo_next;
    logic [PW-1:0] pending_next;

    // Ammo must cover every queued shot, so a press is only taken while
    // there is a round not already spoken for.
    assign ack_take = (state == REQ) && fire_ack;
    assign accept   = press_pulse && (pending < PEND_FULL) && (MW'(ammo) > MW'(pending));
    assign refill   = reload || auto_fire;

    always_comb begin
        ammo_next = ammo;
        if (refill) begin
            ammo_next = AMMO_FULL;
        end else if (ack_take) begin
            ammo_next = ammo - AW'(1);
        end
    end

    always_comb begin
        pending_next = pending;
        case ({accept, ack_take})
            2'b10:   pending_next = pending + PW'(1);
            2'b01:   pending_next = pending - PW'(1);
            default: pending_next = pending;
        endcase
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cool_cnt <= '0;
        end else begin
            state    <= state_next;
            cool_cnt <= cool_cnt_next;
        end
    end

    // The last cooldown cycle hands straight to REQ so the gap between an
    // ack and the next request is exactly COOLDOWN cycles.
    always_comb begin
        state_next    = state;
        cool_cnt_next = cool_cnt;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (fire_ack) begin
                    if (COOLDOWN == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next    = COOL;
                        cool_cnt_next = COOL_LOAD;
                    end
                end
            end
            COOL: begin
                if (cool_cnt == '0) begin
                    state_next = (pending != '0) ? REQ : IDLE;
                end else begin
                    cool_cnt_next = cool_cnt - CW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                cool_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            fire_req   <= 1'b0;
            ammo       <= AMMO_FULL;
            pending    <= '0;
            empty      <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            fire_req   <= (state_next == REQ);
            ammo       <= ammo_next;
            pending    <= pending_next;
            empty      <= (ammo_next == '0);
            drop_pulse <= press_pulse && !accept;
        end
    end

`ifdef FIRE_CTRL_AUTO_RELOAD_EN
    localparam int RW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam logic [RW-1:0] RELOAD_LOAD = RW'(RELOAD_CYCLES - 1);

    logic          drained;
    logic [RW-1:0] reload_cnt;

    // Dropped presses leave pending at zero, so they never disturb the count.
    assign drained   = (ammo == '0) && (pending == '0);
    assign auto_fire = drained && !reload && (reload_cnt == '0);

    always_ff @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            reload_cnt <= RELOAD_LOAD;
        end else if (reload || !drained || auto_fire) begin
            reload_cnt <= RELOAD_LOAD;
        end else begin
            reload_cnt <= reload_cnt - RW'(1);
        end
    end
`else
    logic unused_reload_cfg;

    assign auto_fire         = 1'b0;
    assign unused_reload_cfg = ^RELOAD_CYCLES;
`endif

endmodule

// File: tb/tb_fire_request_controller.sv
// Bench for fire_request_controller: directed scenarios plus random traffic,
// all checked every cycle against a queue/gap-count model of the controller.

module tb_fire_request_controller;

    localparam int AMMO_MAX      = 8;
    localparam int PEND_MAX      = 3;
    localparam int COOLDOWN      = 4;
    localparam int RELOAD_CYCLES = 16;

    logic       fclk        = 1'b0;
    logic       reset_n     = 1'b1;
    logic       press_pulse = 1'b0;
    logic       reload      = 1'b0;
    logic       fire_ack    = 1'b0;
    logic       fire_req;
    logic [3:0] ammo;
    logic [1:0] pending;
    logic       empty;
    logic       drop_pulse;

    fire_request_controller #(
        .AMMO_MAX      (AMMO_MAX),
        .PEND_MAX      (PEND_MAX),
        .COOLDOWN      (COOLDOWN),
        .RELOAD_CYCLES (RELOAD_CYCLES)
    ) dut (
        .fclk        (fclk),
        .reset_n     (reset_n),
        .press_pulse (press_pulse),
        .reload      (reload),
        .fire_ack    (fire_ack),
        .fire_req    (fire_req),
        .ammo        (ammo),
        .pending     (pending),
        .empty       (empty),
        .drop_pulse  (drop_pulse)
    );

    always #5 fclk = ~fclk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: counts of rounds and queued shots, plus "gap" = cycles of forced
    // silence still owed after an acknowledged shot.
    int m_ammo, m_pend, m_gap, m_rl;
    bit m_req, m_drop;
    int n_ammo, n_pend, n_gap, n_rl;
    bit n_req, n_drop, ack_ev, acc;

    always_comb begin
        ack_ev = m_req && fire_ack;
        acc    = press_pulse && (m_pend < PEND_MAX) && (m_ammo > m_pend);
        n_pend = m_pend + int'(acc) - int'(ack_ev);
        n_ammo = reload ? AMMO_MAX : m_ammo - int'(ack_ev);
        n_drop = press_pulse && !acc;
        n_rl   = 0;
        if (!reload && m_ammo == 0 && m_pend == 0) begin
            n_rl = m_rl + 1;
            if (n_rl == RELOAD_CYCLES) begin
`ifdef FIRE_CTRL_AUTO_RELOAD_EN
                n_ammo = AMMO_MAX;
`endif
                n_rl = 0;
            end
        end
        n_gap = 0;
        n_req = 1'b0;
        if (ack_ev) begin
            n_gap = COOLDOWN;
        end else if (m_req) begin
            n_req = 1'b1;
        end else if (m_gap > 1) begin
            n_gap = m_gap - 1;
        end else begin
            n_req = (m_pend > 0);
        end
    end

    always @(posedge fclk or negedge reset_n) begin
        if (!reset_n) begin
            m_ammo <= AMMO_MAX;
            m_pend <= 0;
            m_gap  <= 0;
            m_rl   <= 0;
            m_req  <= 1'b0;
            m_drop <= 1'b0;
        end else begin
            m_ammo <= n_ammo;
            m_pend <= n_pend;
            m_gap  <= n_gap;
            m_rl   <= n_rl;
            m_req  <= n_req;
            m_drop <= n_drop;
        end
    end

    always @(negedge fclk) begin
        if (chk_en) begin
            check("fire_req", int'(fire_req), int'(m_req));
            check("ammo", int'(ammo), m_ammo);
            check("pending", int'(pending), m_pend);
            check("empty", int'(empty), (m_ammo == 0) ? 1 : 0);
            check("drop_pulse", int'(drop_pulse), int'(m_drop));
        end
    end

    task automatic step(input bit p, input bit r, input bit a);
        @(negedge fclk);
        press_pulse = p;
        reload      = r;
        fire_ack    = a;
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (fire_req) break;
        end
        check({name, " req seen"}, int'(fire_req), 1);
    endtask

    initial begin
        int rises[$];
        bit prev;
        int g1, g2, t0, t1;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge fclk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        check("rst fire_req", int'(fire_req), 0);
        check("rst ammo", int'(ammo), AMMO_MAX);
        check("rst pending", int'(pending), 0);
        check("rst empty", int'(empty), 0);
        check("rst drop", int'(drop_pulse), 0);

        // single shot: press cycle 0, req cycle 2, ack cycle 4
        step(1, 0, 0);
        step(0, 0, 0);
        check("t1 pending c1", int'(pending), 1);
        check("t1 req c1", int'(fire_req), 0);
        step(0, 0, 0);
        check("t1 req c2", int'(fire_req), 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        check("t1 req c5", int'(fire_req), 0);
        check("t1 ammo c5", int'(ammo), 7);
        check("t1 pending c5", int'(pending), 0);
        repeat (6) step(0, 0, 0);

        // five presses, no ack: queue saturates
        repeat (5) step(1, 0, 0);
        step(0, 0, 0);
        check("t2 pending sat", int'(pending), 3);
        check("t2 drop", int'(drop_pulse), 1);
        check("t2 req held", int'(fire_req), 1);
        step(0, 1, 0);

        // ack tied high: requests spaced COOLDOWN+1 apart
        prev = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(0, 0, 1);
            if (fire_req && !prev) rises.push_back(i);
            prev = fire_req;
        end
        check("t3 req count", rises.size(), 3);
        g1 = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
        g2 = (rises.size() >= 3) ? rises[2] - rises[1] : -1;
        check("t3 gap1", g1, 5);
        check("t3 gap2", g2, 5);
        check("t3 ammo", int'(ammo), 5);

        // drain to empty, then reload
        for (int i = 0; i < 30; i++) step(i < 28, 0, 1);
        step(1, 0, 0);
        step(0, 0, 0);
        check("t4 empty", int'(empty), 1);
        check("t4 drop", int'(drop_pulse), 1);
        check("t4 ammo", int'(ammo), 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("t4 reload ammo", int'(ammo), AMMO_MAX);
        check("t4 reload empty", int'(empty), 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("t4 accept after reload", int'(pending), 1);
        check("t4 no drop", int'(drop_pulse), 0);

        // coincident press+ack, then reload+ack
        wait_req("t5a");
        check("t5 pending before", int'(pending), 1);
        press_pulse = 1'b1;
        fire_ack    = 1'b1;
        step(0, 0, 0);
        check("t5 press+ack pending", int'(pending), 1);
        check("t5 press+ack ammo", int'(ammo), 7);
        wait_req("t5b");
        reload   = 1'b1;
        fire_ack = 1'b1;
        step(0, 0, 0);
        check("t5 reload+ack ammo", int'(ammo), AMMO_MAX);
        check("t5 reload+ack pending", int'(pending), 0);

        // reset in the middle of a handshake
        step(1, 0, 0);
        step(1, 0, 0);
        wait_req("t6");
        check("t6 pending before rst", int'(pending), 2);
        #2 reset_n = 1'b0;
        #1;
        check("t6 rst req", int'(fire_req), 0);
        check("t6 rst pending", int'(pending), 0);
        check("t6 rst ammo", int'(ammo), AMMO_MAX);
        step(0, 0, 0);
        #2 reset_n = 1'b1;

        // drain all rounds, then watch for (or against) auto reload
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 80; i++) begin
            step((i < 36) || (i == 50), 0, 1);
            if (t0 < 0 && ammo == 4'd0 && pending == 2'd0) t0 = i;
            if (t0 >= 0 && t1 < 0 && int'(ammo) == AMMO_MAX) t1 = i;
        end
        check("t7 drain cycle", t0, 38);
`ifdef FIRE_CTRL_AUTO_RELOAD_EN
        check("t7 auto reload delay", t1 - t0, RELOAD_CYCLES);
        check("t7 auto reload ammo", int'(ammo), AMMO_MAX);
`else
        check("t7 no auto reload", int'(ammo), 0);
        check("t7 still empty", int'(empty), 1);
`endif
        step(0, 1, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                step(0, 0, 0);
                #2 reset_n = 1'b0;
                step(0, 0, 0);
                #2 reset_n = 1'b1;
            end else begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 1)));
            end
        end
        step(0, 0, 0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
